tdm_demux_4bit: RTL and testbench
=================================

TDM_DEMUX_4BIT -- requirements
Module: tdm_demux_4bit

Interface
REQ-001 Parameter: WIDTH, default 4, data word width in bits; all channel and data ports SHALL use WIDTH.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Port clk, input, 1: clock; all state changes occur on its rising edge.
REQ-004 Port rst, input, 1: asynchronous active-high reset.
REQ-005 Port din, input, WIDTH: time-multiplexed data word from the 4-channel TDM bus.
REQ-006 Port din_valid, input, 1: din holds a valid slot word this cycle.
REQ-007 Port sync, input, 1: qualified by din_valid, marks the current word as slot 0, i.e. frame start.
REQ-008 Ports ch0, ch1, ch2, ch3, output, WIDTH each: registered last-received word per channel.
REQ-009 Port ch_valid, output, 4: one-cycle strobe; bit n means chn was updated this cycle.
REQ-010 Port frame_done, output, 1: one-cycle strobe when slot 3 of a frame is delivered.
REQ-011 Port sync_err, output, 1: one-cycle strobe on a framing violation.

Function
REQ-012 States SHALL be IDLE (unsynchronised) and RUN (synchronised), with a 2-bit slot counter (0..3).
REQ-013 All outputs SHALL be registered; a word accepted at edge k SHALL appear on chN, with its ch_valid bit, after edge k. Latency is 1 cycle.
REQ-014 ch_valid, frame_done and sync_err SHALL default to 0 and SHALL pulse for exactly one cycle per event.
REQ-015 Cycles with din_valid=0 SHALL change no state and no channel register, and SHALL produce no strobes; sync is ignored in these cycles.
REQ-016 In IDLE, din_valid=1 with sync=0 SHALL be discarded silently, with no sync_err.
REQ-017 In IDLE, din_valid=1 with sync=1 SHALL perform all of: load ch0 <= din, pulse ch_valid[0], set slot to 1, and enter RUN.
REQ-018 In RUN with slot=s in 1..3, din_valid=1 with sync=0 SHALL load ch[s] <= din, pulse ch_valid[s], and increment slot.
REQ-019 When slot 3 is accepted, the block SHALL pulse frame_done in the same cycle as ch_valid[3], wrap slot to 0, and stay in RUN.
REQ-020 In RUN with slot=0, din_valid=1 with sync=1 SHALL load ch0, pulse ch_valid[0], and set slot to 1, starting a back-to-back frame.
REQ-021 In RUN with slot=0, din_valid=1 with sync=0 is a missing sync; the block SHALL discard the word, pulse sync_err, clear slot to 0, and enter IDLE.
REQ-022 In RUN with slot in 1..3, din_valid=1 with sync=1 is an early sync and SHALL be handled as follows:
- pulse sync_err;
- treat the word as a new slot 0 (load ch0, pulse ch_valid[0], slot to 1);
- leave the channels of the aborted frame holding their old values;
- do not pulse frame_done.
REQ-023 Channel registers not addressed in a cycle SHALL hold their value.
REQ-024 At most one ch_valid bit SHALL be high in any cycle.

Reset
REQ-025 When rst=1, the block SHALL immediately, without waiting for clk, clear ch0..ch3, ch_valid, frame_done, sync_err and slot to 0, and force IDLE.
REQ-026 While rst=1, all inputs SHALL be ignored.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; after release, only a din_valid&sync word restarts reception.

Verification
REQ-028 Bench SHALL cover a nominal frame:
- stimulus: after reset, 4 consecutive valid words 4'hA(sync), 4'h5, 4'h3, 4'hC;
- response: ch0..ch3=A,5,3,C; ch_valid=0001,0010,0100,1000 on successive cycles; frame_done high only with 1000.
REQ-029 Bench SHALL cover gaps:
- stimulus: the same frame with din_valid=0 for 2 cycles between each word;
- response: identical channel values; no strobes during gap cycles.
REQ-030 Bench SHALL cover early sync:
- stimulus: 4'h1(sync), 4'h2, then 4'h7(sync);
- response: sync_err pulses once; ch0=7; ch1=2 unchanged; ch2 and ch3 remain 0; no frame_done.
REQ-031 Bench SHALL cover missing sync:
- stimulus: a full frame, then a valid word 4'hF with sync=0;
- response: sync_err pulses once; channels unchanged; a later 4'hF with sync=0 is ignored without sync_err.
REQ-032 Bench SHALL cover reset mid-frame:
- stimulus: assert rst between clock edges after slot 1;
- response: all outputs 0 before the next edge; after release, a non-sync word is ignored.
REQ-033 Bench SHALL cover back-to-back frames:
- stimulus: two frames with no idle cycle between them;
- response: frame_done pulses twice; ch0..ch3 hold the second frame's values; no sync_err.

Source files
------------

// File: rtl/tdm_demux_4bit.sv
// Four-channel TDM demultiplexer: sync-qualified framing with a slot counter, one
// registered output word per channel, and one-cycle update, frame and error strobes.
module tdm_demux_4bit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic [3:0]       ch_valid,
    output logic             frame_done,
    output logic             sync_err
);

    typedef enum logic [0:0] {StIdle, StRun} state_t;

    state_t     state;
    logic [1:0] slot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            slot       <= 2'd0;
            ch0        <= '0;
            ch1        <= '0;
            ch2        <= '0;
            ch3        <= '0;
            ch_valid   <= 4'b0000;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            ch_valid   <= 4'b0000;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            if (din_valid) begin
                unique case (state)
                    StIdle: begin
                        // Non-sync words are dropped silently until a frame start is seen.
                        if (sync) begin
                            ch0      <= din;
                            ch_valid <= 4'b0001;
                            slot     <= 2'd1;
                            state    <= StRun;
                        end
                    end
                    StRun: begin
                        if (sync) begin
                            // Sync mid-frame aborts the old frame; the word still starts a new one.
                            ch0      <= din;
                            ch_valid <= 4'b0001;
                            slot     <= 2'd1;
                            if (slot != 2'd0) begin
                                sync_err <= 1'b1;
                            end
                        end else if (slot == 2'd0) begin
                            sync_err <= 1'b1;
                            slot     <= 2'd0;
                            state    <= StIdle;
                        end else begin
                            case (slot)
                                2'd1:    ch1 <= din;
                                2'd2:    ch2 <= din;
                                default: ch3 <= din;
                            endcase
                            ch_valid <= 4'b0001 << slot;
                            if (slot == 2'd3) begin
                                frame_done <= 1'b1;
                            end
                            slot <= slot + 2'd1;
                        end
                    end
                    default: begin
                        state <= StIdle;
                        slot  <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_4bit.sv
// Directed bench for tdm_demux_4bit: nominal, gapped, early/missing sync, mid-frame
// reset and back-to-back frames, with hand-computed expectations.
module tb_tdm_demux_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic       din_valid;
    logic       sync;
    logic [3:0] ch0, ch1, ch2, ch3;
    logic [3:0] ch_valid;
    logic       frame_done;
    logic       sync_err;

    int checks = 0;
    int errors = 0;

    tdm_demux_4bit #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sync       (sync),
        .ch0        (ch0),
        .ch1        (ch1),
        .ch2        (ch2),
        .ch3        (ch3),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one input cycle and sample #1 after the capturing edge.
    task automatic word(input logic v, input logic s, input logic [3:0] d);
        din_valid = v;
        sync      = s;
        din       = d;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        sync      = 1'b0;
        din       = 4'h0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        din_valid = 1'b0;
        sync      = 1'b0;
        din       = 4'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_chans(input string tag, input logic [15:0] exp);
        check({tag, "_ch0"}, ch0, exp[15:12]);
        check({tag, "_ch1"}, ch1, exp[11:8]);
        check({tag, "_ch2"}, ch2, exp[7:4]);
        check({tag, "_ch3"}, ch3, exp[3:0]);
    endtask

    task automatic check_strobes(input string tag, input logic [3:0] cv, input logic fd,
                                 input logic se);
        check({tag, "_cv"}, ch_valid, cv);
        check({tag, "_fd"}, frame_done, fd);
        check({tag, "_se"}, sync_err, se);
    endtask

    logic [3:0] nom [4];
    logic [3:0] f2  [4];
    int fd_cnt;
    int se_cnt;

    initial begin
        nom = '{4'hA, 4'h5, 4'h3, 4'hC};
        f2  = '{4'h8, 4'h9, 4'hA, 4'hB};

        // Reset state
        do_reset();
        check_chans("rst", 16'h0000);
        check_strobes("rst", 4'b0000, 1'b0, 1'b0);

        // Nominal frame
        word(1'b1, 1'b1, 4'hA);
        check("nom0_ch0", ch0, 4'hA);
        check_strobes("nom0", 4'b0001, 1'b0, 1'b0);
        word(1'b1, 1'b0, 4'h5);
        check("nom1_ch1", ch1, 4'h5);
        check_strobes("nom1", 4'b0010, 1'b0, 1'b0);
        word(1'b1, 1'b0, 4'h3);
        check("nom2_ch2", ch2, 4'h3);
        check_strobes("nom2", 4'b0100, 1'b0, 1'b0);
        word(1'b1, 1'b0, 4'hC);
        check_chans("nom3", 16'hA53C);
        check_strobes("nom3", 4'b1000, 1'b1, 1'b0);
        word(1'b0, 1'b0, 4'h0);
        check_strobes("nom_idle", 4'b0000, 1'b0, 1'b0);

        // Gapped frame: idle cycles produce no strobes and hold channels
        do_reset();
        for (int i = 0; i < 4; i++) begin
            word(1'b1, (i == 0), nom[i]);
            check_strobes($sformatf("gap_w%0d", i), 4'b0001 << i, (i == 3), 1'b0);
            for (int g = 0; g < 2; g++) begin
                // sync high during an idle cycle must also be ignored
                word(1'b0, 1'b1, 4'hF);
                check_strobes($sformatf("gap_w%0d_g%0d", i, g), 4'b0000, 1'b0, 1'b0);
            end
        end
        check_chans("gap_end", 16'hA53C);

        // Early sync
        do_reset();
        word(1'b1, 1'b1, 4'h1);
        word(1'b1, 1'b0, 4'h2);
        word(1'b1, 1'b1, 4'h7);
        check_strobes("early", 4'b0001, 1'b0, 1'b1);
        check_chans("early", 16'h7200);
        word(1'b0, 1'b0, 4'h0);
        check_strobes("early_after", 4'b0000, 1'b0, 1'b0);
        word(1'b1, 1'b0, 4'h6);
        check("early_resume_ch1", ch1, 4'h6);
        check_strobes("early_resume", 4'b0010, 1'b0, 1'b0);

        // Missing sync
        do_reset();
        for (int i = 0; i < 4; i++) word(1'b1, (i == 0), nom[i]);
        word(1'b1, 1'b0, 4'hF);
        check_strobes("miss", 4'b0000, 1'b0, 1'b1);
        check_chans("miss", 16'hA53C);
        word(1'b1, 1'b0, 4'hF);
        check_strobes("miss_idle", 4'b0000, 1'b0, 1'b0);
        check_chans("miss_idle", 16'hA53C);

        // Reset mid-frame, asserted between edges
        do_reset();
        word(1'b1, 1'b1, 4'h9);
        word(1'b1, 1'b0, 4'h6);
        #2;
        rst = 1'b1;
        #1;
        check_chans("arst", 16'h0000);
        check_strobes("arst", 4'b0000, 1'b0, 1'b0);
        // Inputs are ignored while reset is held across an edge
        din_valid = 1'b1;
        sync      = 1'b1;
        din       = 4'hE;
        @(posedge clk);
        #1;
        check("arst_hold_ch0", ch0, 4'h0);
        check("arst_hold_cv", ch_valid, 4'b0000);
        din_valid = 1'b0;
        sync      = 1'b0;
        rst       = 1'b0;
        word(1'b1, 1'b0, 4'h4);
        check_chans("arst_nosync", 16'h0000);
        check_strobes("arst_nosync", 4'b0000, 1'b0, 1'b0);
        word(1'b1, 1'b1, 4'hB);
        check("arst_restart_ch0", ch0, 4'hB);
        check("arst_restart_cv", ch_valid, 4'b0001);

        // Back-to-back frames
        do_reset();
        fd_cnt = 0;
        se_cnt = 0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 4; i++) begin
                word(1'b1, (i == 0), (f == 0) ? nom[i] : f2[i]);
                check($sformatf("b2b_f%0d_cv%0d", f, i), ch_valid, 4'b0001 << i);
                if (frame_done) fd_cnt++;
                if (sync_err) se_cnt++;
            end
        end
        check("b2b_fd_count", fd_cnt, 2);
        check("b2b_se_count", se_cnt, 0);
        check_chans("b2b", 16'h89AB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
